// File: rtl/trig_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : trig_frame_capture
// Brief    : Armed, trigger-aligned frame capture into block RAM with a
//            registered random-access readout port. Define PRETRIG_EN to keep
//            a circular pre-trigger history of PRE_SAMPLES samples.
// Revision : 1.0  initial release
// ============================================================================
module trig_frame_capture #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int PRE_SAMPLES = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              trigger,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              done
);

    localparam int c_DEPTH = 2 ** ADDR_W;
`ifdef PRETRIG_EN
    localparam int c_POST  = c_DEPTH - PRE_SAMPLES;
`else
    localparam int c_POST  = c_DEPTH;
`endif
    localparam logic [ADDR_W:0] c_POST_W = (ADDR_W+1)'(c_POST);

    generate
        if (PRE_SAMPLES >= c_DEPTH) begin : g_pre_range_check
            $error("PRE_SAMPLES must be smaller than 2**ADDR_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W:0]     r_post_cnt;
    logic [DATA_W-1:0]   r_rd_data;
    logic [DATA_W-1:0]   r_mem [0:c_DEPTH-1];
    logic                w_we;
    logic                w_post_inc;
    logic                w_arm_ok;
    logic                w_trig_ok;
    logic                w_post_last;

`ifdef PRETRIG_EN
    logic [ADDR_W-1:0]   r_fill_cnt;
    logic [ADDR_W-1:0]   r_start_addr;

    // Only a full history yields a frame with PRE_SAMPLES valid pre-trigger words.
    assign w_trig_ok  = trigger && (r_fill_cnt == ADDR_W'(PRE_SAMPLES));
    assign start_addr = r_start_addr;
`else
    assign w_trig_ok  = trigger;
    assign start_addr = '0;
`endif

    assign w_post_last = (r_post_cnt + (ADDR_W+1)'(1)) == c_POST_W;
    assign busy        = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
    assign done        = (r_state == ST_DONE);
    assign rd_data     = r_rd_data;

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_post_inc  = 1'b0;
        w_arm_ok    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    w_arm_ok    = 1'b1;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
`ifdef PRETRIG_EN
                w_we = data_in_valid;
`endif
                if (w_trig_ok) begin
                    // A sample coincident with the trigger is post-trigger sample 0.
                    w_we        = data_in_valid;
                    w_post_inc  = data_in_valid;
                    w_state_nxt = (data_in_valid && w_post_last) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_we       = data_in_valid;
                w_post_inc = data_in_valid;
                if (data_in_valid && w_post_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_post_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_arm_ok) begin
                r_wr_ptr   <= '0;
                r_post_cnt <= '0;
            end else begin
                if (w_we) begin
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                end
                if (w_post_inc) begin
                    r_post_cnt <= r_post_cnt + (ADDR_W+1)'(1);
                end
            end
        end
    end

`ifdef PRETRIG_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fill_cnt   <= '0;
            r_start_addr <= '0;
        end else begin
            if (w_arm_ok) begin
                r_fill_cnt <= '0;
            end else if ((r_state == ST_ARMED) && data_in_valid &&
                         (r_fill_cnt != ADDR_W'(PRE_SAMPLES))) begin
                r_fill_cnt <= r_fill_cnt + ADDR_W'(1);
            end
            if ((r_state == ST_ARMED) && w_trig_ok) begin
                r_start_addr <= r_wr_ptr - ADDR_W'(PRE_SAMPLES);
            end
        end
    end
`endif

    // Plain RAM write port kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trig_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_trig_frame_capture
// Brief    : Directed self-checking bench for trig_frame_capture (DEPTH 16,
//            PRE_SAMPLES 4); frame readback is table driven.
// Revision : 1.0  initial release
// ============================================================================
module tb_trig_frame_capture;

    localparam int c_DW = 32;
    localparam int c_AW = 4;
`ifdef PRETRIG_EN
    localparam int c_PRE = 4;
`else
    localparam int c_PRE = 0;
`endif
    localparam int c_POST = 16 - c_PRE;

    typedef struct {
        logic [c_AW-1:0] addr;
        logic [c_DW-1:0] exp;
    } rd_vec_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            arm;
    logic            trigger;
    logic [c_DW-1:0] data_in;
    logic            data_in_valid;
    logic [c_AW-1:0] rd_addr;
    logic [c_DW-1:0] rd_data;
    logic [c_AW-1:0] start_addr;
    logic            busy;
    logic            done;

    int n_cmp = 0;
    int n_bad = 0;

    trig_frame_capture #(
        .DATA_W      (c_DW),
        .ADDR_W      (c_AW),
        .PRE_SAMPLES (4)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .arm           (arm),
        .trigger       (trigger),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .start_addr    (start_addr),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [c_DW-1:0] act, input logic [c_DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic t, input logic v, input int d);
        arm           = a;
        trigger       = t;
        data_in_valid = v;
        data_in       = c_DW'(d);
        @(posedge clk);
        #1;
        arm           = 1'b0;
        trigger       = 1'b0;
        data_in_valid = 1'b0;
    endtask

    task automatic do_arm(input string nm);
        drive(1'b1, 1'b0, 1'b0, 0);
        check({nm, " busy after arm"}, 32'(busy), 32'd1);
        check({nm, " done after arm"}, 32'(done), 32'd0);
    endtask

    // Feeds n_pre untriggered samples, then a trigger-aligned post frame.
    task automatic capture(input int wr0, input int n_pre, input int base, input bit extra_arm,
                           input string nm, output int exp_base, output int exp_start);
        for (int i = 0; i < n_pre; i++) drive(1'b0, 1'b0, 1'b1, base + i);
        for (int i = 0; i < c_POST; i++) begin
            if (i == c_POST - 1) begin
                check({nm, " busy before last"}, 32'(busy), 32'd1);
                check({nm, " done before last"}, 32'(done), 32'd0);
            end
            drive(extra_arm && (i == 3), i == 0, 1'b1, base + n_pre + i);
        end
        check({nm, " done after last"}, 32'(done), 32'd1);
        check({nm, " busy after last"}, 32'(busy), 32'd0);
        exp_base  = base + n_pre - c_PRE;
        exp_start = (c_PRE == 0) ? 0 : ((wr0 + n_pre - c_PRE) & 15);
    endtask

    task automatic check_frame(input string nm, input int base, input int st);
        rd_vec_t tbl [16];
        for (int i = 0; i < 16; i++) begin
            tbl[i].addr = c_AW'((st + i) % 16);
            tbl[i].exp  = c_DW'(base + i);
        end
        check({nm, " start_addr"}, 32'(start_addr), 32'(st));
        for (int i = 0; i < 16; i++) begin
            rd_addr = tbl[i].addr;
            @(posedge clk);
            #1;
            check($sformatf("%s rd[%0d]", nm, i), rd_data, tbl[i].exp);
        end
    endtask

    initial begin
        int eb, es;
        reset_n = 1'b0; arm = 1'b0; trigger = 1'b0;
        data_in = '0; data_in_valid = 1'b0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset start_addr", 32'(start_addr), 32'd0);
        check("reset rd_data", rd_data, 32'd0);
        reset_n = 1'b1;

        // Ramp frame, then a trigger while DONE must not disturb it.
        do_arm("t1");
        capture(0, 5, 100, 1'b0, "t1", eb, es);
        drive(1'b0, 1'b1, 1'b1, 999);
        check("t1 done holds on trigger", 32'(done), 32'd1);
        check_frame("t1", eb, es);

        // Re-arm from DONE, trigger coincident with sample 7, stray arm mid-capture.
        do_arm("t2");
        capture(0, 7, 0, 1'b1, "t2", eb, es);
        check_frame("t2", eb, es);

`ifdef PRETRIG_EN
        // Early trigger with an unfilled history must be dropped.
        do_arm("t3");
        drive(1'b0, 1'b0, 1'b1, 0);
        drive(1'b0, 1'b0, 1'b1, 1);
        drive(1'b0, 1'b1, 1'b0, 0);
        check("t3 busy after early trig", 32'(busy), 32'd1);
        check("t3 done after early trig", 32'(done), 32'd0);
        capture(2, 8, 2, 1'b0, "t3", eb, es);
        check("t3 start is 6", 32'(es), 32'd6);
        check_frame("t3", eb, es);
`endif

        // Gapped valid: one sample every third cycle.
        do_arm("t4");
        for (int i = 0; i < c_PRE; i++) drive(1'b0, 1'b0, 1'b1, 196 + i);
        drive(1'b0, 1'b1, 1'b0, 0);
        for (int k = 0; k < c_POST; k++) begin
            drive(1'b0, 1'b0, 1'b0, 0);
            drive(1'b0, 1'b0, 1'b0, 0);
            if (k == c_POST - 1) check("t4 done before last", 32'(done), 32'd0);
            drive(1'b0, 1'b0, 1'b1, 200 + k);
        end
        check("t4 done after last", 32'(done), 32'd1);
        check_frame("t4", 200 - c_PRE, 0);

        // Reset mid-capture, then a trigger with no arm.
        do_arm("t5");
        for (int i = 0; i < c_PRE; i++) drive(1'b0, 1'b0, 1'b1, 300 + i);
        for (int i = 0; i < 8; i++) drive(1'b0, i == 0, 1'b1, 310 + i);
        check("t5 busy mid capture", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("t5 busy after reset", 32'(busy), 32'd0);
        check("t5 done after reset", 32'(done), 32'd0);
        check("t5 start after reset", 32'(start_addr), 32'd0);
        check("t5 rd_data after reset", rd_data, 32'd0);
        drive(1'b0, 1'b1, 1'b1, 5);
        check("t5 busy after idle trig", 32'(busy), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 0);
        check("t5 done after idle trig", 32'(done), 32'd0);
        check("t5 busy stays low", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trig_frame_capture.md
# trig_frame_capture

Triggered frame acquisition stage sitting directly downstream of the level-crossing trigger in the data source path. After being armed, it waits for the one-cycle trigger pulse and stores a fixed-length frame of valid samples from the same stream into internal block RAM. It then holds the frame for readout through a registered random-access port. It gives the host one coherent, trigger-aligned record per arm request.

## Interface
- DATA_W, 32: sample width, two's-complement signed.
- ADDR_W, 10: RAM address width; frame length DEPTH = 2**ADDR_W samples.
- PRE_SAMPLES, 128: pre-trigger samples per frame; used only when PRETRIG_EN is defined; must be < DEPTH.

- clk  in  1: clock.
- reset_n  in  1: reset, synchronous, active-low.
- arm  in  1: single-cycle request to start a new acquisition.
- trigger  in  1: single-cycle trigger pulse from the upstream trigger block.
- data_in  in  DATA_W: sample stream, shared with the trigger block.
- data_in_valid  in  1: sample qualifier.
- rd_addr  in  ADDR_W: readout address.
- rd_data  out  DATA_W: RAM word at rd_addr, registered.
- start_addr  out  ADDR_W: address of the first (oldest) frame sample.
- busy  out  1: high in ARMED or CAPTURE.
- done  out  1: a complete frame is held in RAM.

## Operation
- FSM states: IDLE, ARMED, CAPTURE, DONE.
- IDLE: samples are ignored. arm moves to ARMED; it clears wr_ptr, post_cnt, fill_cnt and done.
- ARMED, without PRETRIG_EN: samples are ignored. trigger moves to CAPTURE.
- ARMED, with PRETRIG_EN: each valid sample is written at wr_ptr, wr_ptr increments and wraps mod DEPTH, and fill_cnt saturates at PRE_SAMPLES.
  - trigger is accepted only when fill_cnt == PRE_SAMPLES. Earlier triggers are dropped with no effect.
- Trigger and valid in the same cycle: that sample is post-trigger sample 0 and is written in that cycle.
- CAPTURE: each valid sample is written at wr_ptr, wr_ptr increments, and post_cnt increments.
  - The write that makes post_cnt reach POST moves the FSM to DONE.
  - POST = DEPTH without PRETRIG_EN; POST = DEPTH − PRE_SAMPLES with PRETRIG_EN.
- DONE: no writes. Frame contents and start_addr are frozen. arm re-enters ARMED.
- arm is ignored in ARMED and CAPTURE. trigger is ignored in IDLE, CAPTURE and DONE.
- start_addr:
  - Without PRETRIG_EN: constant 0.
  - With PRETRIG_EN: latched on trigger acceptance as (wr_ptr − PRE_SAMPLES) mod DEPTH, using wr_ptr before that cycle's write.
- Readout: the host reads sample i at (start_addr + i) mod DEPTH, for i = 0..DEPTH−1. The address wrap is the host's responsibility.
- The read port works in every state. Reads during capture return the current RAM contents, with no coherency guarantee.
- Samples are stored bit-exact; the block does no arithmetic on data.

## Timing
- Reset values: rd_data 0, start_addr 0, busy 0, done 0, state IDLE. RAM contents are not cleared.
- reset_n low mid-capture: the next state is IDLE and the partial frame is abandoned.
- rd_data latency is 1 cycle: rd_addr at edge N produces data valid after edge N+1. A read of an address written in the same cycle returns the old word.
- busy rises 1 cycle after arm is sampled.
- done rises in the cycle after the clock edge that wrote the last frame sample. busy falls at that same edge.
- done falls 1 cycle after arm is sampled in DONE.
- Throughput is one sample per clock; data_in_valid may be high continuously.

## Configuration
- PRETRIG_EN defined: a circular pre-trigger history of PRE_SAMPLES is kept, trigger acceptance is gated on the history being full, and start_addr tracks the frame start.
- PRETRIG_EN undefined: frame = DEPTH post-trigger samples, start_addr tied to 0, and fill_cnt logic is removed.

## Test plan
All scenarios use ADDR_W=4 (DEPTH 16) and PRE_SAMPLES=4.
1. No PRETRIG_EN. arm, then trigger after 5 valid samples, feeding ramp data 100, 101, … → addr 0..15 hold 105..120, done=1, start_addr=0.
2. Trigger coincident with valid on sample value 7 → sample 7 stored at frame index 0.
3. PRETRIG_EN. arm, trigger after 2 valid samples → trigger ignored, state stays ARMED. Second trigger after 10 samples total (ramp 0..9, trigger on sample 10) → frame indices 0..3 hold 6..9, index 4 holds 10, and start_addr = 6.
4. Gapped valid (1 in 3 cycles) during capture → exactly 16 samples captured, with no duplicates or skips. done asserts exactly 1 cycle after the 16th valid.
5. reset_n asserted mid-CAPTURE (after 8 samples) → busy=0, done=0, state IDLE. A following trigger with no arm is ignored.
6. In DONE, arm then trigger → a second frame overwrites the first. Extra arm pulses during CAPTURE have no effect.
